// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage mips32 pipeline: load-use and branch hazards,
// whole-pipeline freeze on data-memory wait, memory-timeout watchdog and stall counter.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifIdRs,
  input  logic [4:0]       ifIdRt,
  input  logic             ifIdUsesRt,
  input  logic             idExMemRead,
  input  logic [4:0]       idExRt,
  input  logic             branchTaken,
  input  logic             memAccess,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             pcSrcBranch,
  output logic             ifIdWrite,
  output logic             ifIdFlush,
  output logic             idExWrite,
  output logic             idExBubble,
  output logic             exMemWrite,
  output logic             memWbWrite,
  output logic [CNT_W-1:0] stallCnt,
  output logic             memError
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } stateT;

  stateT       state, nextState;
  logic        freeze, loadUse, timeout, stallEvent;
  logic [15:0] waitCnt, waitInc;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    freeze  = memAccess & ~memReady;
    loadUse = idExMemRead & (idExRt != 5'd0) &
              ((idExRt == ifIdRs) | (ifIdUsesRt & (idExRt == ifIdRt)));
    waitInc = waitCnt + 16'd1;
    // A ready that arrives on the would-be timeout cycle clears freeze and wins.
    timeout = freeze && (waitInc == 16'(MEM_TIMEOUT));

    nextState = state;
    case (state)
      RUN:      if (freeze)  nextState = MEM_WAIT;
      MEM_WAIT: if (!freeze) nextState = RUN;
      default:  nextState = ERROR;
    endcase
    if (timeout) nextState = ERROR;

    // Freeze and branch flushes are mutually ranked; only freeze and load-use stalls count.
    stallEvent = (state != ERROR) && (freeze || (!branchTaken && loadUse));

    pcWrite     = 1'b0;
    pcSrcBranch = 1'b0;
    ifIdWrite   = 1'b0;
    ifIdFlush   = 1'b0;
    idExWrite   = 1'b0;
    idExBubble  = 1'b0;
    exMemWrite  = 1'b0;
    memWbWrite  = 1'b0;
    if (rst || state == ERROR || freeze) begin
      // Hold everything; pending branch or load-use stays in the held registers.
    end else if (branchTaken) begin
      pcWrite     = 1'b1;
      pcSrcBranch = 1'b1;
      ifIdWrite   = 1'b1;
      ifIdFlush   = 1'b1;
      idExWrite   = 1'b1;
      idExBubble  = 1'b1;
      exMemWrite  = 1'b1;
      memWbWrite  = 1'b1;
    end else if (loadUse) begin
      idExWrite   = 1'b1;
      idExBubble  = 1'b1;
      exMemWrite  = 1'b1;
      memWbWrite  = 1'b1;
    end else begin
      pcWrite     = 1'b1;
      ifIdWrite   = 1'b1;
      idExWrite   = 1'b1;
      exMemWrite  = 1'b1;
      memWbWrite  = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      waitCnt  <= 16'd0;
      stallCnt <= '0;
      memError <= 1'b0;
    end else begin
      state    <= nextState;
      waitCnt  <= freeze ? waitInc : 16'd0;
      memError <= (nextState == ERROR);
      if (stallEvent && (stallCnt != {CNT_W{1'b1}}))
        stallCnt <= stallCnt + CNT_W'(1);
    end
  end

endmodule
